// File: rtl/hilo_muldiv_iter.sv
// Iterative MULT/MULTU/DIV/DIVU unit for the HILO pair; one shift-add or
// restoring shift-subtract step per cycle on unsigned magnitudes, signs fixed at the end.
module hilo_muldiv_iter #(
    parameter int WIDTH     = 32,
    parameter bit FAST_ZERO = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero,
    output logic [1:0]       stateDbg
);
    // Handshake: start is honoured only in IDLE with cancel low; done is a
    // one-cycle pulse after FIX, and hi/lo/div_by_zero stay valid until the next FIX.

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } stateT;

    stateT state, nextState;

    logic [CW-1:0]        counter;
    logic [2*WIDTH-1:0]   work;
    logic [WIDTH-1:0]     mcand;
    logic [WIDTH-1:0]     rawA;
    logic                 opDiv, negRes, negRem, divZero, zeroFlag;

    logic                 isDiv, aNeg, bNeg, goFast, launch;
    logic [WIDTH-1:0]     aMag, bMag;
    logic [WIDTH:0]       mulSum, trial;
    logic [2*WIDTH-1:0]   stepWork, prodFix;
    logic [WIDTH-1:0]     quo, rem, fixHi, fixLo;

    assign isDiv  = op[1];
    assign aNeg   = ~op[0] & a[WIDTH-1];
    assign bNeg   = ~op[0] & b[WIDTH-1];
    assign aMag   = aNeg ? -a : a;
    assign bMag   = bNeg ? -b : b;
    assign goFast = FAST_ZERO && ((a == '0) || (b == '0));
    assign launch = (state == IDLE) && start && !cancel;

    // Multiply: add into the upper half when the multiplier LSB is set, then shift right.
    // Divide: shift {rem, quotient} left and keep the trial subtraction if it did not borrow.
    always_comb begin
        mulSum   = {1'b0, work[2*WIDTH-1:WIDTH]} + {1'b0, (work[0] ? mcand : '0)};
        trial    = work[2*WIDTH-1:WIDTH-1] - {1'b0, mcand};
        stepWork = {mulSum, work[WIDTH-1:1]};
        if (opDiv) begin
            if (trial[WIDTH])
                stepWork = {work[2*WIDTH-2:0], 1'b0};
            else
                stepWork = {trial[WIDTH-1:0], work[WIDTH-2:0], 1'b1};
        end
    end

    always_comb begin
        prodFix = negRes ? -work : work;
        quo     = negRes ? -work[WIDTH-1:0] : work[WIDTH-1:0];
        rem     = negRem ? -work[2*WIDTH-1:WIDTH] : work[2*WIDTH-1:WIDTH];
        fixHi   = prodFix[2*WIDTH-1:WIDTH];
        fixLo   = prodFix[WIDTH-1:0];
        if (divZero) begin
            fixHi = rawA;
            fixLo = '1;
        end else if (opDiv) begin
            fixHi = rem;
            fixLo = quo;
        end else if (zeroFlag) begin
            fixHi = '0;
            fixLo = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= nextState;
    end

    always_comb begin
        nextState = state;
        busy      = 1'b0;
        case (state)
            IDLE: if (launch) nextState = goFast ? FIX : RUN;
            RUN: begin
                busy = 1'b1;
                if (cancel)               nextState = IDLE;
                else if (counter == '0)   nextState = FIX;
            end
            FIX: begin
                busy      = 1'b1;
                nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    assign stateDbg = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            counter     <= '0;
            work        <= '0;
            mcand       <= '0;
            rawA        <= '0;
            opDiv       <= 1'b0;
            negRes      <= 1'b0;
            negRem      <= 1'b0;
            divZero     <= 1'b0;
            zeroFlag    <= 1'b0;
            done        <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (launch) begin
                    opDiv    <= isDiv;
                    negRes   <= aNeg ^ bNeg;
                    negRem   <= aNeg;
                    divZero  <= isDiv && (b == '0);
                    zeroFlag <= goFast;
                    rawA     <= a;
                    counter  <= CW'(WIDTH - 1);
                    mcand    <= isDiv ? bMag : aMag;
                    work     <= {{WIDTH{1'b0}}, (isDiv ? aMag : bMag)};
                end
                RUN: if (!cancel) begin
                    counter <= counter - 1'b1;
                    work    <= stepWork;
                end
                FIX: if (!cancel) begin
                    hi          <= fixHi;
                    lo          <= fixLo;
                    div_by_zero <= divZero;
                    done        <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_hilo_muldiv_iter.sv
// Bench for hilo_muldiv_iter: three instances (32-bit fast-zero, 32-bit full latency,
// 8-bit) run every directed vector side by side against an arithmetic reference model.
module tb_hilo_muldiv_iter;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0, b = '0;
    logic        cancel = 1'b0;

    logic        busy0, busy1, busy8, done0, done1, done8, dbz0, dbz1, dbz8;
    logic [31:0] hi0, lo0, hi1, lo1;
    logic [7:0]  hi8, lo8;
    logic [1:0]  st0, st1, st8;

    logic        busyV[3], doneV[3], dbzV[3];
    logic [31:0] hiV[3], loV[3];

    int          vecs = 0;
    int          fails = 0;
    int          wArr[3] = '{32, 32, 8};
    int          fzArr[3] = '{1, 0, 1};
    logic [64:0] expQ[3][$];
    logic [64:0] prevRes[3] = '{65'd0, 65'd0, 65'd0};

    always #5 clk = ~clk;

    hilo_muldiv_iter #(.WIDTH(32), .FAST_ZERO(1'b1)) uFast (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .cancel(cancel),
        .busy(busy0), .done(done0), .hi(hi0), .lo(lo0), .div_by_zero(dbz0), .stateDbg(st0));
    hilo_muldiv_iter #(.WIDTH(32), .FAST_ZERO(1'b0)) uSlow (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .cancel(cancel),
        .busy(busy1), .done(done1), .hi(hi1), .lo(lo1), .div_by_zero(dbz1), .stateDbg(st1));
    hilo_muldiv_iter #(.WIDTH(8), .FAST_ZERO(1'b1)) uNarrow (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a[7:0]), .b(b[7:0]), .cancel(cancel),
        .busy(busy8), .done(done8), .hi(hi8), .lo(lo8), .div_by_zero(dbz8), .stateDbg(st8));

    always_comb begin
        busyV[0] = busy0; busyV[1] = busy1; busyV[2] = busy8;
        doneV[0] = done0; doneV[1] = done1; doneV[2] = done8;
        dbzV[0]  = dbz0;  dbzV[1]  = dbz1;  dbzV[2]  = dbz8;
        hiV[0]   = hi0;   hiV[1]   = hi1;   hiV[2]   = {24'd0, hi8};
        loV[0]   = lo0;   loV[1]   = lo1;   loV[2]   = {24'd0, lo8};
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic at width w (truncating signed division).
    function automatic void model(input int w, input logic [1:0] o, input logic [31:0] ai,
                                  input logic [31:0] bi, output logic [31:0] h,
                                  output logic [31:0] l, output logic z);
        logic [63:0] mask, ua, ub, pb;
        longint      sa, sb, q, r;
        mask = (64'd1 << w) - 64'd1;
        ua   = {32'd0, ai} & mask;
        ub   = {32'd0, bi} & mask;
        sa   = ua[w-1] ? longint'(ua) - longint'(64'd1 << w) : longint'(ua);
        sb   = ub[w-1] ? longint'(ub) - longint'(64'd1 << w) : longint'(ub);
        z    = 1'b0;
        if (!o[1]) begin
            pb = o[0] ? ua * ub : 64'(sa * sb);
            h  = 32'((pb >> w) & mask);
            l  = 32'(pb & mask);
        end else if (ub == 64'd0) begin
            z = 1'b1;
            h = 32'(ua);
            l = 32'(mask);
        end else if (o[0]) begin
            h = 32'((ua % ub) & mask);
            l = 32'((ua / ub) & mask);
        end else begin
            q = sa / sb;
            r = sa % sb;
            h = 32'(64'(r) & mask);
            l = 32'(64'(q) & mask);
        end
    endfunction

    task automatic pinModel(input int w, input logic [1:0] o, input logic [31:0] ai,
                            input logic [31:0] bi, input logic [31:0] eh, input logic [31:0] el,
                            input logic ez);
        logic [31:0] h, l;
        logic        z;
        model(w, o, ai, bi, h, l, z);
        check("model_hi", h, eh);
        check("model_lo", l, el);
        check("model_dbz", {31'd0, z}, {31'd0, ez});
    endtask

    task automatic checkIdleZero(input string tag);
        for (int i = 0; i < 3; i++) begin
            check({tag, "_busy"}, {31'd0, busyV[i]}, 32'd0);
            check({tag, "_done"}, {31'd0, doneV[i]}, 32'd0);
            check({tag, "_hi"}, hiV[i], 32'd0);
            check({tag, "_lo"}, loV[i], 32'd0);
            check({tag, "_dbz"}, {31'd0, dbzV[i]}, 32'd0);
        end
    endtask

    // One operation on all instances; restartAt/cancelAt > 0 inject a stray start
    // or a flush that many edges after the accepting edge.
    task automatic runOp(input string tag, input logic [1:0] o, input logic [31:0] ai,
                         input logic [31:0] bi, input int restartAt, input int cancelAt);
        int          lat[3], endCyc[3];
        logic        killed[3];
        logic [31:0] h, l, m;
        logic        z;
        logic [64:0] e;
        for (int i = 0; i < 3; i++) begin
            model(wArr[i], o, ai, bi, h, l, z);
            m = (wArr[i] == 32) ? 32'hFFFF_FFFF : 32'h0000_00FF;
            lat[i] = (fzArr[i] != 0 && (((ai & m) == 0) || ((bi & m) == 0))) ? 1 : wArr[i] + 1;
            killed[i] = (cancelAt > 0) && (cancelAt < lat[i]);
            endCyc[i] = killed[i] ? cancelAt + 1 : lat[i];
            expQ[i].push_back(killed[i] ? prevRes[i] : {z, h, l});
        end
        @(negedge clk);
        op = o; a = ai; b = bi; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 3; i++) check({tag, "_busy0"}, {31'd0, busyV[i]}, 32'd1);
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(posedge clk); #1;
            for (int i = 0; i < 3; i++) begin
                check({tag, "_busy"}, {31'd0, busyV[i]}, {31'd0, cyc < endCyc[i]});
                check({tag, "_done"}, {31'd0, doneV[i]}, {31'd0, !killed[i] && cyc == lat[i]});
            end
            if (cyc == restartAt) begin start = 1'b1; a = ai ^ 32'hFFFF_0F0F; b = bi + 32'd3; end
            if (cyc == restartAt + 1) begin start = 1'b0; a = ai; b = bi; end
            if (cyc == cancelAt) cancel = 1'b1;
            if (cyc == cancelAt + 1) cancel = 1'b0;
        end
        for (int i = 0; i < 3; i++) begin
            e = expQ[i].pop_front();
            check({tag, "_hi"}, hiV[i], e[63:32]);
            check({tag, "_lo"}, loV[i], e[31:0]);
            check({tag, "_dbz"}, {31'd0, dbzV[i]}, {31'd0, e[64]});
            prevRes[i] = e;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Model pins against hand-worked values.
        pinModel(32, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        pinModel(32, 2'b00, -32'sd7, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        pinModel(32, 2'b10, -32'sd7, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        pinModel(32, 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
        pinModel(32, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0);
        pinModel(32, 2'b11, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1);
        pinModel(8, 2'b00, 32'h80, 32'h80, 32'h40, 32'h00, 1'b0);

        repeat (3) @(posedge clk);
        #1 checkIdleZero("reset");
        @(negedge clk) rst = 1'b1;

        runOp("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
        runOp("mult_neg", 2'b00, -32'sd7, 32'd3, 0, 0);
        runOp("div_neg", 2'b10, -32'sd7, 32'd2, 0, 0);
        runOp("divu", 2'b11, 32'd100, 32'd7, 0, 0);
        runOp("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
        runOp("divu_zero", 2'b11, 32'd5, 32'd0, 0, 0);
        runOp("mult_min8", 2'b00, 32'h80, 32'h80, 0, 0);
        runOp("mult_zero", 2'b00, 32'd0, 32'd12345, 0, 0);
        runOp("div_zero_s", 2'b10, -32'sd100, 32'd0, 0, 0);
        runOp("div_negdiv", 2'b10, 32'd7, -32'sd2, 0, 0);
        runOp("div_bothneg", 2'b10, -32'sd7, -32'sd2, 0, 0);
        runOp("restart", 2'b01, 32'd123456789, 32'd1000, 3, 0);
        runOp("cancel", 2'b01, 32'h1234_5678, 32'h9ABC_DEF1, 0, 5);

        // Reset in the middle of a DIVU clears everything at once.
        @(negedge clk);
        op = 2'b11; a = 32'd1000; b = 32'd7; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (20) @(posedge clk);
        #3 rst = 1'b0;
        #1 checkIdleZero("async_rst");
        @(negedge clk) rst = 1'b1;
        for (int i = 0; i < 3; i++) prevRes[i] = '0;

        runOp("after_rst", 2'b11, 32'd9, 32'd3, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end
endmodule
